// File: rtl/bcd_time_keeper_if.sv
//----------------------------------------------------------------------------
// bcd_time_keeper_if
//
// Purpose: groups the time-set, alarm-write and time-output signals of the
// BCD time keeper into one bundle. The master side (a controller or bench)
// drives the one-second tick, set requests and alarm writes; the slave side
// (the time keeper) returns the registered time and the status pulses.
//
// Signals:
//   ena                    one-second tick qualifier
//   set_vld                load time from set_hh/set_mm/set_ss/set_pm
//   set_hh/set_mm/set_ss   packed BCD time to load (tens [7:4], units [3:0])
//   set_pm                 pm value to load (12-hour build only)
//   alm_wr                 write alarm registers
//   alm_hh/alm_mm          packed BCD alarm time
//   alm_pm                 alarm pm (12-hour build only)
//   alm_on                 alarm armed level
//   hh/mm/ss               current packed BCD time
//   pm                     pm flag
//   day_wrap               one-cycle pulse on day rollover
//   alarm                  one-cycle pulse on alarm match
//   set_err                one-cycle pulse on a rejected set or alarm write
//----------------------------------------------------------------------------
interface bcd_time_keeper_if;
    logic       ena;
    logic       set_vld;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_pm;
    logic       alm_wr;
    logic [7:0] alm_hh;
    logic [7:0] alm_mm;
    logic       alm_pm;
    logic       alm_on;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       day_wrap;
    logic       alarm;
    logic       set_err;

    modport master (
        output ena, set_vld, set_hh, set_mm, set_ss, set_pm,
        output alm_wr, alm_hh, alm_mm, alm_pm, alm_on,
        input  hh, mm, ss, pm, day_wrap, alarm, set_err
    );

    modport slave (
        input  ena, set_vld, set_hh, set_mm, set_ss, set_pm,
        input  alm_wr, alm_hh, alm_mm, alm_pm, alm_on,
        output hh, mm, ss, pm, day_wrap, alarm, set_err
    );
endinterface

// File: rtl/bcd_time_keeper.sv
//----------------------------------------------------------------------------
// bcd_time_keeper
//
// Purpose: time-of-day counter kept directly in packed BCD. Advances one
// second per ena tick, supports loading a new time, holds a single alarm
// time and reports day rollover, alarm match and rejected writes as
// registered one-cycle pulses.
//
// Parameters:
//   HOUR24    0 = 12-hour display (12,01..11) with pm flag, 1 = 24-hour
//   ALARM_EN  1 = alarm pulse generated, 0 = alarm output held low
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    slave side of bcd_time_keeper_if (see that file for signals)
//----------------------------------------------------------------------------
module bcd_time_keeper #(
    parameter int HOUR24   = 0,
    parameter int ALARM_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    bcd_time_keeper_if.slave  bus
);

    // Midnight is shown as 12 AM in the 12-hour build and 00 in the 24-hour one.
    localparam logic [7:0] RESET_HH = (HOUR24 != 0) ? 8'h00 : 8'h12;

    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       pm_q, pm_d;
    logic [7:0] almHh_q;
    logic [7:0] almMm_q;
    logic       almPm_q;
    logic       dayWrap_q, dayWrap_d;
    logic       alarm_q, alarm_d;
    logic       setErr_q, setErr_d;

    logic       ssCarry;
    logic       mmCarry;
    logic [7:0] incHh;
    logic [7:0] incMm;
    logic [7:0] incSs;
    logic       incPm;
    logic       setOk;
    logic       almOk;
    logic       tick;
    logic       almWrite;

    // Both nibbles must be decimal digits before any range compare is trusted.
    function automatic logic digitsOk(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // With both nibbles decimal, a plain binary compare orders BCD values correctly.
    function automatic logic hourOk(input logic [7:0] h);
        if (HOUR24 != 0)
            return h <= 8'h23;
        else
            return (h >= 8'h01) && (h <= 8'h12);
    endfunction

    function automatic logic timeOk(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s);
        return digitsOk(h) && digitsOk(m) && digitsOk(s) &&
               (m <= 8'h59) && (s <= 8'h59) && hourOk(h);
    endfunction

    // Add one to a packed BCD value, rolling the units digit into the tens.
    function automatic logic [7:0] bump(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 12-hour display wraps 12 -> 01; 24-hour wraps 23 -> 00.
    function automatic logic [7:0] nextHour(input logic [7:0] h);
        if (HOUR24 != 0)
            return (h == 8'h23) ? 8'h00 : bump(h);
        else
            return (h == 8'h12) ? 8'h01 : bump(h);
    endfunction

    // Candidate time one second ahead of the current time. In 12-hour mode the
    // pm flag flips only when 11:59:59 rolls to 12:00:00; in 24-hour mode it
    // is simply derived from the new hour.
    always_comb begin
        ssCarry = 1'b0;
        mmCarry = 1'b0;
        incSs   = ss_q;
        incMm   = mm_q;
        incHh   = hh_q;
        incPm   = pm_q;

        ssCarry = (ss_q == 8'h59);
        mmCarry = ssCarry && (mm_q == 8'h59);
        incSs   = ssCarry ? 8'h00 : bump(ss_q);
        if (ssCarry)
            incMm = mmCarry ? 8'h00 : bump(mm_q);
        if (mmCarry)
            incHh = nextHour(hh_q);
        if (HOUR24 != 0)
            incPm = (incHh >= 8'h12);
        else
            incPm = pm_q ^ (mmCarry && (hh_q == 8'h11));
    end

    // Next-state selection. A valid set wins over the tick and swallows it;
    // a rejected set lets the tick through. Day-wrap and alarm pulses are only
    // raised by a tick, never by a load, and compare against the alarm value
    // held before any write in this same cycle.
    always_comb begin
        hh_d      = hh_q;
        mm_d      = mm_q;
        ss_d      = ss_q;
        pm_d      = pm_q;
        dayWrap_d = 1'b0;
        alarm_d   = 1'b0;
        setErr_d  = 1'b0;
        setOk     = 1'b0;
        almOk     = 1'b0;
        tick      = 1'b0;
        almWrite  = 1'b0;

        setOk    = bus.set_vld && timeOk(bus.set_hh, bus.set_mm, bus.set_ss);
        almOk    = timeOk(bus.alm_hh, bus.alm_mm, 8'h00);
        tick     = bus.ena && !setOk;
        almWrite = bus.alm_wr && almOk;

        if (setOk) begin
            hh_d = bus.set_hh;
            mm_d = bus.set_mm;
            ss_d = bus.set_ss;
            pm_d = (HOUR24 != 0) ? (bus.set_hh >= 8'h12) : bus.set_pm;
        end else if (tick) begin
            hh_d = incHh;
            mm_d = incMm;
            ss_d = incSs;
            pm_d = incPm;
        end

        dayWrap_d = tick && (incHh == RESET_HH) && (incMm == 8'h00) &&
                    (incSs == 8'h00) && !incPm;

        alarm_d = (ALARM_EN != 0) && tick && bus.alm_on &&
                  (incHh == almHh_q) && (incMm == almMm_q) && (incSs == 8'h00) &&
                  ((HOUR24 != 0) || (incPm == almPm_q));

        setErr_d = (bus.set_vld && !setOk) || (bus.alm_wr && !almOk);
    end

    // Time and pulse registers; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            hh_q      <= RESET_HH;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            pm_q      <= 1'b0;
            dayWrap_q <= 1'b0;
            alarm_q   <= 1'b0;
            setErr_q  <= 1'b0;
        end else begin
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            pm_q      <= pm_d;
            dayWrap_q <= dayWrap_d;
            alarm_q   <= alarm_d;
            setErr_q  <= setErr_d;
        end
    end

    // Alarm registers start at midnight and change only on an accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            almHh_q <= RESET_HH;
            almMm_q <= 8'h00;
            almPm_q <= 1'b0;
        end else if (almWrite) begin
            almHh_q <= bus.alm_hh;
            almMm_q <= bus.alm_mm;
            almPm_q <= (HOUR24 != 0) ? 1'b0 : bus.alm_pm;
        end
    end

    assign bus.hh       = hh_q;
    assign bus.mm       = mm_q;
    assign bus.ss       = ss_q;
    assign bus.pm       = pm_q;
    assign bus.day_wrap = dayWrap_q;
    assign bus.alarm    = alarm_q;
    assign bus.set_err  = setErr_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
//----------------------------------------------------------------------------
// tb_bcd_time_keeper
//
// Purpose: drives a 12-hour and a 24-hour instance of bcd_time_keeper with
// the same stimulus and compares both against a seconds-of-day reference
// model. Directed steps cover rollover, rejected writes, alarms and reset;
// a randomized phase follows.
//----------------------------------------------------------------------------
module tb_bcd_time_keeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       setVld;
    logic [7:0] setHh;
    logic [7:0] setMm;
    logic [7:0] setSs;
    logic       setPm;
    logic       almWr;
    logic [7:0] almHh;
    logic [7:0] almMm;
    logic       almPm;
    logic       almOn;

    int testCount = 0;
    int failCount = 0;

    // Reference state: time and alarm as seconds since midnight per format.
    int   secs       [2];
    int   almSecs    [2];
    logic expDayWrap [2];
    logic expAlarm   [2];
    logic expSetErr  [2];

    bcd_time_keeper_if bus12 ();
    bcd_time_keeper_if bus24 ();

    assign bus12.ena     = ena;
    assign bus12.set_vld = setVld;
    assign bus12.set_hh  = setHh;
    assign bus12.set_mm  = setMm;
    assign bus12.set_ss  = setSs;
    assign bus12.set_pm  = setPm;
    assign bus12.alm_wr  = almWr;
    assign bus12.alm_hh  = almHh;
    assign bus12.alm_mm  = almMm;
    assign bus12.alm_pm  = almPm;
    assign bus12.alm_on  = almOn;

    assign bus24.ena     = ena;
    assign bus24.set_vld = setVld;
    assign bus24.set_hh  = setHh;
    assign bus24.set_mm  = setMm;
    assign bus24.set_ss  = setSs;
    assign bus24.set_pm  = setPm;
    assign bus24.alm_wr  = almWr;
    assign bus24.alm_hh  = almHh;
    assign bus24.alm_mm  = almMm;
    assign bus24.alm_pm  = almPm;
    assign bus24.alm_on  = almOn;

    bcd_time_keeper #(.HOUR24(0), .ALARM_EN(1)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12)
    );

    bcd_time_keeper #(.HOUR24(1), .ALARM_EN(1)) dut24 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus24)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        forever #5 clk = ~clk;
    end

    // Decimal value of a packed BCD byte, or -1 when a nibble is not a digit.
    function automatic int bcdVal(input logic [7:0] v);
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9))
            return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] toBcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // Validate a requested time and convert it to seconds since midnight.
    function automatic logic parseTime(input int f, input logic [7:0] h,
                                       input logic [7:0] m, input logic [7:0] s,
                                       input logic p, output int sod);
        int hv;
        int mv;
        int sv;
        int h24;
        hv  = bcdVal(h);
        mv  = bcdVal(m);
        sv  = bcdVal(s);
        sod = 0;
        h24 = 0;
        if ((hv < 0) || (mv < 0) || (mv > 59) || (sv < 0) || (sv > 59))
            return 1'b0;
        if (f == 0) begin
            if ((hv < 1) || (hv > 12))
                return 1'b0;
            h24 = (hv % 12) + (p ? 12 : 0);
        end else begin
            if (hv > 23)
                return 1'b0;
            h24 = hv;
        end
        sod = h24 * 3600 + mv * 60 + sv;
        return 1'b1;
    endfunction

    // Advance the reference model by one clock edge using the driven inputs.
    task automatic modelStep(input int f);
        int   sSod;
        int   aSod;
        logic sOk;
        logic aOk;
        if (reset) begin
            secs[f]       = 0;
            almSecs[f]    = 0;
            expDayWrap[f] = 1'b0;
            expAlarm[f]   = 1'b0;
            expSetErr[f]  = 1'b0;
        end else begin
            sOk = parseTime(f, setHh, setMm, setSs, setPm, sSod);
            aOk = parseTime(f, almHh, almMm, 8'h00, almPm, aSod);
            expDayWrap[f] = 1'b0;
            expAlarm[f]   = 1'b0;
            if (setVld && sOk) begin
                secs[f] = sSod;
            end else if (ena) begin
                secs[f]       = (secs[f] + 1) % 86400;
                expDayWrap[f] = (secs[f] == 0);
                expAlarm[f]   = almOn && (secs[f] == almSecs[f]);
            end
            expSetErr[f] = (setVld && !sOk) || (almWr && !aOk);
            if (almWr && aOk)
                almSecs[f] = aSod;
        end
    endtask

    task automatic checkByte(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkFmt(input int f, input string step,
                            input logic [7:0] oHh, input logic [7:0] oMm,
                            input logic [7:0] oSs, input logic oPm,
                            input logic oDw, input logic oAl, input logic oEr);
        int    h24;
        int    hDisp;
        string fmt;
        fmt   = (f == 0) ? "12h" : "24h";
        h24   = secs[f] / 3600;
        hDisp = (f == 0) ? (((h24 % 12) == 0) ? 12 : (h24 % 12)) : h24;
        checkByte($sformatf("%s/%s hh", step, fmt), oHh, toBcd(hDisp));
        checkByte($sformatf("%s/%s mm", step, fmt), oMm, toBcd((secs[f] / 60) % 60));
        checkByte($sformatf("%s/%s ss", step, fmt), oSs, toBcd(secs[f] % 60));
        checkBit($sformatf("%s/%s pm", step, fmt), oPm, (h24 >= 12));
        checkBit($sformatf("%s/%s day_wrap", step, fmt), oDw, expDayWrap[f]);
        checkBit($sformatf("%s/%s alarm", step, fmt), oAl, expAlarm[f]);
        checkBit($sformatf("%s/%s set_err", step, fmt), oEr, expSetErr[f]);
    endtask

    task automatic checkOutput(input string step);
        checkFmt(0, step, bus12.hh, bus12.mm, bus12.ss, bus12.pm,
                 bus12.day_wrap, bus12.alarm, bus12.set_err);
        checkFmt(1, step, bus24.hh, bus24.mm, bus24.ss, bus24.pm,
                 bus24.day_wrap, bus24.alarm, bus24.set_err);
    endtask

    // Drive one cycle of inputs, step the model at the edge, then compare.
    task automatic applyStimulus(input string step, input logic rst, input logic en,
                                 input logic sv, input logic [7:0] sh,
                                 input logic [7:0] sm, input logic [7:0] sc,
                                 input logic sp, input logic aw,
                                 input logic [7:0] ah, input logic [7:0] am,
                                 input logic ap, input logic ao);
        reset  = rst;
        ena    = en;
        setVld = sv;
        setHh  = sh;
        setMm  = sm;
        setSs  = sc;
        setPm  = sp;
        almWr  = aw;
        almHh  = ah;
        almMm  = am;
        almPm  = ap;
        almOn  = ao;
        @(posedge clk);
        #1;
        modelStep(0);
        modelStep(1);
        checkOutput(step);
    endtask

    task automatic setTime(input string step, input logic en, input logic [7:0] sh,
                           input logic [7:0] sm, input logic [7:0] sc, input logic sp,
                           input logic ao);
        applyStimulus(step, 1'b0, en, 1'b1, sh, sm, sc, sp,
                      1'b0, 8'h00, 8'h00, 1'b0, ao);
    endtask

    task automatic tickOnce(input string step, input logic ao);
        applyStimulus(step, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b0, 8'h00, 8'h00, 1'b0, ao);
    endtask

    function automatic logic [7:0] randField(input int maxVal);
        if ($urandom_range(0, 9) == 0)
            return 8'($urandom_range(0, 255));
        return toBcd(int'($urandom_range(0, maxVal)));
    endfunction

    initial begin
        // Reset state.
        applyStimulus("reset0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus("idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // 11:59:58 PM over midnight.
        setTime("set115958pm", 1'b0, 8'h11, 8'h59, 8'h58, 1'b1, 1'b0);
        tickOnce("tick115959", 1'b0);
        tickOnce("tickMidnight", 1'b0);
        tickOnce("tickAfterMidnight", 1'b0);

        // 12:59:59 AM -> 01:00:00, and 11:59:59 AM -> noon.
        setTime("set125959am", 1'b0, 8'h12, 8'h59, 8'h59, 1'b0, 1'b0);
        tickOnce("tick010000", 1'b0);
        setTime("set115959am", 1'b0, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
        tickOnce("tickNoon", 1'b0);

        // 23:59:59 (rejected in 12h, tick applied there) then 24h midnight.
        setTime("set235959", 1'b0, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        tickOnce("tick24Midnight", 1'b0);
        setTime("set00", 1'b1, 8'h00, 8'h30, 8'h00, 1'b0, 1'b0);

        // Rejected sets with a coincident tick.
        setTime("set051020", 1'b0, 8'h05, 8'h10, 8'h20, 1'b0, 1'b0);
        setTime("badMm60", 1'b1, 8'h05, 8'h60, 8'h00, 1'b0, 1'b0);
        setTime("badSs1A", 1'b1, 8'h05, 8'h10, 8'h1A, 1'b0, 1'b0);
        setTime("goodSetDropsTick", 1'b1, 8'h09, 8'h08, 8'h07, 1'b1, 1'b0);
        tickOnce("afterErr", 1'b0);

        // Alarm at 07:30 AM, armed then disarmed.
        applyStimulus("almWr0730", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b1, 8'h07, 8'h30, 1'b0, 1'b1);
        setTime("set072959", 1'b0, 8'h07, 8'h29, 8'h59, 1'b0, 1'b1);
        tickOnce("alarmHit", 1'b1);
        tickOnce("alarmDone", 1'b1);
        setTime("set072959b", 1'b0, 8'h07, 8'h29, 8'h59, 1'b0, 1'b0);
        tickOnce("alarmDisarmed", 1'b0);
        setTime("setAtAlarm", 1'b0, 8'h07, 8'h30, 8'h00, 1'b0, 1'b1);

        // Alarm write coincident with a matching tick uses the old alarm.
        setTime("set072959c", 1'b0, 8'h07, 8'h29, 8'h59, 1'b0, 1'b1);
        applyStimulus("almWrOnHit", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b1, 8'h08, 8'h00, 1'b0, 1'b1);
        setTime("set075959", 1'b0, 8'h07, 8'h59, 8'h59, 1'b0, 1'b1);
        tickOnce("newAlarmHit", 1'b1);

        // Rejected alarm writes: hour 13 only valid in 24h, 7A never valid.
        applyStimulus("almWr13", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      1'b1, 8'h13, 8'h00, 1'b0, 1'b1);
        applyStimulus("almWr7A", 1'b0, 1'b0, 1'b1, 8'h15, 8'h00, 8'h00, 1'b0,
                      1'b1, 8'h01, 8'h7A, 1'b0, 1'b1);

        // Reset mid-count overrides set, tick and alarm write.
        setTime("set094533", 1'b0, 8'h09, 8'h45, 8'h33, 1'b0, 1'b1);
        tickOnce("count", 1'b1);
        applyStimulus("resetOverride", 1'b1, 1'b1, 1'b1, 8'h03, 8'h04, 8'h05, 1'b1,
                      1'b1, 8'h02, 8'h02, 1'b1, 1'b1);
        tickOnce("afterReset", 1'b0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            int   sel;
            int   hv;
            int   mv;
            logic pv;
            logic ao;
            sel = int'($urandom_range(0, 99));
            ao  = ($urandom_range(0, 4) != 0);
            pv  = 1'($urandom_range(0, 1));
            if (sel < 3) begin
                // Arm an alarm a few seconds ahead of a freshly loaded time.
                hv = int'($urandom_range(1, 12));
                mv = int'($urandom_range(1, 59));
                applyStimulus($sformatf("rand%0d", i), 1'b0, 1'b1, 1'b1, toBcd(hv),
                              toBcd(mv - 1), toBcd(int'($urandom_range(55, 59))), pv,
                              1'b1, toBcd(hv), toBcd(mv), pv, ao);
            end else if (sel < 6) begin
                // Load a time just before midnight in one format or the other.
                applyStimulus($sformatf("rand%0d", i), 1'b0, 1'b0, 1'b1,
                              ($urandom_range(0, 1) == 0) ? 8'h11 : 8'h23, 8'h59,
                              toBcd(int'($urandom_range(50, 59))), 1'b1,
                              1'b0, 8'h00, 8'h00, 1'b0, ao);
            end else if (sel < 10) begin
                applyStimulus($sformatf("rand%0d", i), 1'b0, 1'($urandom_range(0, 1)),
                              1'b1, randField(23), randField(59), randField(59), pv,
                              1'($urandom_range(0, 1)), randField(23), randField(59),
                              1'($urandom_range(0, 1)), ao);
            end else if (sel == 10) begin
                applyStimulus($sformatf("rand%0d", i), 1'b1, 1'b1, 1'b0, 8'h00, 8'h00,
                              8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ao);
            end else begin
                applyStimulus($sformatf("rand%0d", i), 1'b0,
                              ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 8'h00, 8'h00,
                              1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ao);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_time_keeper.md
BCD_TIME_KEEPER -- requirements
Module: bcd_time_keeper

Interface
REQ-001 Parameter: HOUR24, default 0, 0 = 12-hour format with pm flag, 1 = 24-hour format.
REQ-002 Parameter: ALARM_EN, default 1, 1 = alarm logic present, 0 = alarm logic absent and alarm tied 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset reset, synchronous, active-high; clock clk.
REQ-005 ena  input  1  one-second tick, single-cycle qualifier.
REQ-006 set_vld  input  1  load time from set_hh/set_mm/set_ss/set_pm this cycle.
REQ-007 set_hh, set_mm, set_ss  input  8 each  packed BCD time to load, tens in [7:4], units in [3:0].
REQ-008 set_pm  input  1  pm value to load; ignored when HOUR24=1.
REQ-009 alm_wr  input  1  write alarm registers this cycle.
REQ-010 alm_hh, alm_mm  input  8 each  packed BCD alarm time.
REQ-011 alm_pm  input  1  alarm pm; ignored when HOUR24=1.
REQ-012 alm_on  input  1  alarm armed level.
REQ-013 hh, mm, ss  output  8 each  registered packed BCD current time.
REQ-014 pm  output  1  registered; 12h: AM=0/PM=1; 24h: 1 when hh >= 12.
REQ-015 day_wrap  output  1  registered one-cycle pulse on day rollover.
REQ-016 alarm  output  1  registered one-cycle pulse on alarm match.
REQ-017 set_err  output  1  registered one-cycle pulse on rejected set or alarm write.

Function
REQ-018 Priority per cycle: reset > set_vld > ena; alm_wr is independent of all three.
REQ-019 ena=1 without set_vld: advance one second; ss 00..59, carry to mm 00..59, carry to hh.
REQ-020 Hour sequence, HOUR24=0: 12,01,02..11,12; pm toggles exactly on 11:59:59 -> 12:00:00.
REQ-021 Hour sequence, HOUR24=1: 00..23 then 00; pm is recomputed from the new hh every update.
REQ-022 Each BCD digit counts 0..9; no digit ever holds A..F; all three fields update in the same edge.
REQ-023 ena=0 and set_vld=0: time and pm hold.
REQ-024 set_vld validity: every digit <=9; ss<=59; mm<=59; hh in 01..12 (HOUR24=0) or 00..23 (HOUR24=1).
REQ-025 Valid set: hh/mm/ss load next edge, pm=set_pm (12h) or derived (24h); a coincident ena tick is dropped.
REQ-026 Invalid set: time unchanged, ena tick still applied, set_err=1 next cycle.
REQ-027 alm_wr: same validity rules (alarm seconds fixed 00); valid stores alm_hh/alm_mm/alm_pm; invalid leaves alarm registers unchanged and pulses set_err.
REQ-028 set_err is the OR of set and alarm rejections in the same cycle, one pulse.
REQ-029 day_wrap=1 for the single cycle in which outputs first show the day start: 12:00:00 pm=0 (12h) or 00:00:00 (24h), reached by an ena increment only.
REQ-030 alarm=1 for the single cycle in which outputs first equal alarm hh:mm:00 (and pm in 12h), reached by an ena increment only, with alm_on=1 and ALARM_EN=1.
REQ-031 Reaching day start or alarm time through set_vld produces no day_wrap or alarm pulse.
REQ-032 Alarm registers written in the same cycle as a matching increment use the old alarm value for that cycle.

Reset
REQ-033 On reset: HOUR24=0 -> hh=8'h12, mm=8'h00, ss=8'h00, pm=0; HOUR24=1 -> hh=8'h00, mm=8'h00, ss=8'h00, pm=0.
REQ-034 On reset: alarm registers = 12:00 AM (12h) or 00:00 (24h); day_wrap, alarm, set_err = 0.
REQ-035 Reset mid-count, or reset coincident with set_vld/alm_wr/ena, overrides all of them; those inputs are ignored that cycle.

Verification
REQ-036 HOUR24=0, set 11:59:58 pm=1, two ena ticks -> 11:59:59 pm=1, then 12:00:00 pm=0, day_wrap high one cycle.
REQ-037 HOUR24=0, set 12:59:59 pm=0, ena -> 01:00:00 pm=0, no day_wrap; set 11:59:59 pm=0, ena -> 12:00:00 pm=1.
REQ-038 HOUR24=1, set 23:59:59, ena -> 00:00:00 pm=0, day_wrap pulse; set 11:59:59, ena -> 12:00:00 pm=1.
REQ-039 set_vld with set_mm=8'h60 or set_ss=8'h1A, concurrent ena from 05:10:20 -> time becomes 05:10:21, set_err pulse.
REQ-040 alm_wr 07:30 pm=0, alm_on=1, time 07:29:59 pm=0, ena -> 07:30:00 and alarm pulse; repeat with alm_on=0 -> no pulse.
REQ-041 Reset asserted at 09:45:33 with set_vld and ena high -> next cycle 12:00:00 pm=0 (HOUR24=0), all pulse outputs 0.
